// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard controller for the 5-stage pipeline. It produces the
//            stall and flush controls for the IF/ID, ID/EX and EX/MEM stage
//            registers. It handles:
//              - load-use hazards, which cost one bubble
//              - taken branches and jumps resolved in MEM, which squash
//                three instructions
//              - multi-cycle data-memory busy, which freezes the pipeline
//            A busy watchdog raises a sticky timeout flag.
//
// Ports    : clk, rst              - clock, synchronous active-high reset
//            ID_EX_MemRead/RegRt   - load in EX and its destination
//            IF_ID_RegisterRs/Rt   - sources of the instruction in ID
//            EX_MEM_Branch_taken   - taken branch in MEM
//            EX_MEM_Jump           - jump in MEM
//            Mem_busy              - data memory not yet complete
//            PC_Write, IF_ID_Write - fetch-side enables
//            IF_Flush, ID_Hazard_lwstall, ID_Hazard_Branch, EX_Flush, Freeze
//                                  - stage-register controls
//            Hazard_timeout        - sticky watchdog flag
//            stall_count, flush_count - performance counters
//
// Options  : HAZARD_PERF_CNT_EN    - when defined, the performance counters
//            are built. Otherwise stall_count and flush_count read zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned MAX_BUSY = 64,   // must be >= 1
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             EX_MEM_Branch_taken,
    input  logic             EX_MEM_Jump,
    input  logic             Mem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_Hazard_lwstall,
    output logic             ID_Hazard_Branch,
    output logic             EX_Flush,
    output logic             Freeze,
    output logic             Hazard_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned c_BUSY_W = $clog2(MAX_BUSY + 1);
    localparam logic [c_BUSY_W-1:0] c_BUSY_MAX  = c_BUSY_W'(MAX_BUSY);
    localparam logic [c_BUSY_W-1:0] c_BUSY_LAST = c_BUSY_W'(MAX_BUSY - 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LW_BUBBLE = 2'd1,
        S_FROZEN    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic w_lw_hz;
    logic w_redirect;
    logic w_lw_honour;

    logic [c_BUSY_W-1:0] busy_cnt_q;
    logic                timeout_q;

    // $zero is never a real dependency, so a load to r0 never stalls.
    assign w_lw_hz = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                     ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                      (ID_EX_RegisterRt == IF_ID_RegisterRt));

    assign w_redirect = EX_MEM_Branch_taken | EX_MEM_Jump;

    // The cycle right after a bubble still shows the same load in EX.
    // Mask it so that the same hazard does not trigger a second bubble.
    // The cycle that leaves FROZEN is treated like RUN.
    assign w_lw_honour = w_lw_hz && (state_q != S_LW_BUBBLE);

    // ------------------------------------------------------------------
    // Control outputs: combinational, priority busy > redirect > lw_hz
    // ------------------------------------------------------------------
    always_comb begin
        PC_Write          = 1'b0;
        IF_ID_Write       = 1'b0;
        IF_Flush          = 1'b0;
        ID_Hazard_lwstall = 1'b0;
        ID_Hazard_Branch  = 1'b0;
        EX_Flush          = 1'b0;
        Freeze            = 1'b0;
        if (rst) begin
            // All controls are held low.
        end else if (Mem_busy) begin
            // EX/MEM is held, so any pending redirect is seen again
            // once the memory completes.
            Freeze = 1'b1;
        end else if (w_redirect) begin
            PC_Write         = 1'b1;
            IF_ID_Write      = 1'b1;
            IF_Flush         = 1'b1;
            ID_Hazard_Branch = 1'b1;
            EX_Flush         = 1'b1;
        end else if (w_lw_honour) begin
            ID_Hazard_lwstall = 1'b1;
        end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_RUN;
        case (state_q)
            S_RUN, S_FROZEN: begin
                if (Mem_busy) begin
                    state_d = S_FROZEN;
                end else if (w_lw_hz && !w_redirect) begin
                    state_d = S_LW_BUBBLE;
                end
            end
            S_LW_BUBBLE: begin
                if (Mem_busy) begin
                    state_d = S_FROZEN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Busy watchdog. The flag sets on the edge where the count of
    // consecutive busy cycles reaches MAX_BUSY, and it stays set until
    // reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (Mem_busy) begin
            if (busy_cnt_q != c_BUSY_MAX) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
            end
            if (busy_cnt_q == c_BUSY_LAST) begin
                timeout_q <= 1'b1;
            end
        end else begin
            busy_cnt_q <= '0;
        end
    end

    assign Hazard_timeout = timeout_q;

    // ------------------------------------------------------------------
    // Optional performance counters. They saturate and never wrap.
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((ID_Hazard_lwstall || Freeze) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (IF_Flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
`default_nettype wire
